// File: rtl/csr_counters_pkg.sv
// Shared types and constants for the machine performance counters.
package csr_counters_pkg;

  typedef logic [63:0] CounterT;

  // CSR addresses of the counters and their inhibit register.
  localparam logic [11:0] MCYCLE        = 12'hB00;
  localparam logic [11:0] MINSTRET      = 12'hB02;
  localparam logic [11:0] MCYCLEH       = 12'hB80;
  localparam logic [11:0] MINSTRETH     = 12'hB82;
  localparam logic [11:0] MCOUNTINHIBIT = 12'h320;

  // Bit positions within mcountinhibit.
  localparam int unsigned CY = 0;
  localparam int unsigned IR = 2;

endpackage

// File: rtl/csr_counter_unit.sv
// One 64-bit performance counter split into two CSR halves. Software writes
// to either half take priority over the increment; the next value is exported
// combinationally so the CSR instances update on the same edge as the counter.
module csr_counter_unit #(
  parameter int unsigned CounterWidth = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      inhibit,
  input  logic                      wr_lo,
  input  logic                      wr_hi,
  input  logic [CounterWidth/2-1:0] wr_data,
  output logic [CounterWidth/2-1:0] ext_data_lo,
  output logic [CounterWidth/2-1:0] ext_data_hi,
  output logic                      ext_we_lo,
  output logic                      ext_we_hi,
  output logic [CounterWidth-1:0]   value,
  output logic                      wrap
);

  localparam int unsigned HalfWidth = CounterWidth / 2;

  logic [CounterWidth-1:0] cnt_q, cnt_d;
  logic                    wrap_q, wrap_d;
  logic                    inc;
  logic                    lo_full;

  assign lo_full = &cnt_q[HalfWidth-1:0];

  // Next-state selection: writes beat the increment, increment beats hold.
  always_comb begin
    cnt_d  = cnt_q;
    inc    = 1'b0;
    wrap_d = 1'b0;
    if (wr_lo && wr_hi) begin
      cnt_d = {wr_data, wr_data};
    end else if (wr_lo) begin
      cnt_d = {cnt_q[CounterWidth-1:HalfWidth], wr_data};
    end else if (wr_hi) begin
      cnt_d = {wr_data, cnt_q[HalfWidth-1:0]};
    end else if (tick && !inhibit) begin
      inc    = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      wrap_d = &cnt_q;
    end
  end

  // Export to the CSR instances; held quiet while reset is asserted.
  always_comb begin
    ext_data_lo = '0;
    ext_data_hi = '0;
    ext_we_lo   = 1'b0;
    ext_we_hi   = 1'b0;
    if (!reset) begin
      ext_data_lo = cnt_d[HalfWidth-1:0];
      ext_data_hi = cnt_d[CounterWidth-1:HalfWidth];
      ext_we_lo   = wr_lo | inc;
      ext_we_hi   = wr_hi | (inc & lo_full);
    end
  end

  // Counter and wrap-pulse state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign value = cnt_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/csr_counters.sv
// mcycle/minstret counter pair driving the external write paths of their
// CSR register instances. mcycle ticks every cycle, minstret on retire.
module csr_counters
  import csr_counters_pkg::*;
#(
  parameter int unsigned CounterWidth = 64,
  localparam int unsigned HalfWidth = CounterWidth / 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    retire,
  input  logic                    inhibit_cy,
  input  logic                    inhibit_ir,
  input  logic                    cy_wr_lo,
  input  logic                    cy_wr_hi,
  input  logic [HalfWidth-1:0]    cy_wr_data,
  input  logic                    ir_wr_lo,
  input  logic                    ir_wr_hi,
  input  logic [HalfWidth-1:0]    ir_wr_data,
  output logic [HalfWidth-1:0]    cy_ext_data_lo,
  output logic [HalfWidth-1:0]    cy_ext_data_hi,
  output logic                    cy_ext_we_lo,
  output logic                    cy_ext_we_hi,
  output logic [HalfWidth-1:0]    ir_ext_data_lo,
  output logic [HalfWidth-1:0]    ir_ext_data_hi,
  output logic                    ir_ext_we_lo,
  output logic                    ir_ext_we_hi,
  output logic [CounterWidth-1:0] cy_value,
  output logic [CounterWidth-1:0] ir_value,
  output logic                    cy_wrap,
  output logic                    ir_wrap
);

  csr_counter_unit #(
    .CounterWidth(CounterWidth)
  ) u_cycle (
    .clk        (clk),
    .reset      (reset),
    .tick       (1'b1),
    .inhibit    (inhibit_cy),
    .wr_lo      (cy_wr_lo),
    .wr_hi      (cy_wr_hi),
    .wr_data    (cy_wr_data),
    .ext_data_lo(cy_ext_data_lo),
    .ext_data_hi(cy_ext_data_hi),
    .ext_we_lo  (cy_ext_we_lo),
    .ext_we_hi  (cy_ext_we_hi),
    .value      (cy_value),
    .wrap       (cy_wrap)
  );

  csr_counter_unit #(
    .CounterWidth(CounterWidth)
  ) u_instret (
    .clk        (clk),
    .reset      (reset),
    .tick       (retire),
    .inhibit    (inhibit_ir),
    .wr_lo      (ir_wr_lo),
    .wr_hi      (ir_wr_hi),
    .wr_data    (ir_wr_data),
    .ext_data_lo(ir_ext_data_lo),
    .ext_data_hi(ir_ext_data_hi),
    .ext_we_lo  (ir_ext_we_lo),
    .ext_we_hi  (ir_ext_we_hi),
    .value      (ir_value),
    .wrap       (ir_wrap)
  );

endmodule

// File: tb/tb_csr_counters.sv
// Directed bench for csr_counters; outputs sampled on the falling edge.
module tb_csr_counters;

  logic        clk;
  logic        reset;
  logic        retire;
  logic        inhibit_cy;
  logic        inhibit_ir;
  logic        cy_wr_lo;
  logic        cy_wr_hi;
  logic [31:0] cy_wr_data;
  logic        ir_wr_lo;
  logic        ir_wr_hi;
  logic [31:0] ir_wr_data;
  logic [31:0] cy_ext_data_lo;
  logic [31:0] cy_ext_data_hi;
  logic        cy_ext_we_lo;
  logic        cy_ext_we_hi;
  logic [31:0] ir_ext_data_lo;
  logic [31:0] ir_ext_data_hi;
  logic        ir_ext_we_lo;
  logic        ir_ext_we_hi;
  logic [63:0] cy_value;
  logic [63:0] ir_value;
  logic        cy_wrap;
  logic        ir_wrap;

  int n_assert = 0;
  int n_fail   = 0;

  csr_counters #(
    .CounterWidth(64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .retire        (retire),
    .inhibit_cy    (inhibit_cy),
    .inhibit_ir    (inhibit_ir),
    .cy_wr_lo      (cy_wr_lo),
    .cy_wr_hi      (cy_wr_hi),
    .cy_wr_data    (cy_wr_data),
    .ir_wr_lo      (ir_wr_lo),
    .ir_wr_hi      (ir_wr_hi),
    .ir_wr_data    (ir_wr_data),
    .cy_ext_data_lo(cy_ext_data_lo),
    .cy_ext_data_hi(cy_ext_data_hi),
    .cy_ext_we_lo  (cy_ext_we_lo),
    .cy_ext_we_hi  (cy_ext_we_hi),
    .ir_ext_data_lo(ir_ext_data_lo),
    .ir_ext_data_hi(ir_ext_data_hi),
    .ir_ext_we_lo  (ir_ext_we_lo),
    .ir_ext_we_hi  (ir_ext_we_hi),
    .cy_value      (cy_value),
    .ir_value      (ir_value),
    .cy_wrap       (cy_wrap),
    .ir_wrap       (ir_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_we_all_zero(input string tag);
    chk(tag, {60'd0, cy_ext_we_lo, cy_ext_we_hi, ir_ext_we_lo, ir_ext_we_hi}, 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    retire     = 1'b0;
    inhibit_cy = 1'b0;
    inhibit_ir = 1'b0;
    cy_wr_lo   = 1'b0;
    cy_wr_hi   = 1'b0;
    cy_wr_data = '0;
    ir_wr_lo   = 1'b0;
    ir_wr_hi   = 1'b0;
    ir_wr_data = '0;

    // Reset state
    #2;
    chk("rst_cy_value", cy_value, 64'd0);
    chk("rst_ir_value", ir_value, 64'd0);
    chk("rst_wraps", {62'd0, cy_wrap, ir_wrap}, 64'd0);
    chk_we_all_zero("rst_we");
    chk("rst_cy_data", {cy_ext_data_hi, cy_ext_data_lo}, 64'd0);
    chk("rst_ir_data", {ir_ext_data_hi, ir_ext_data_lo}, 64'd0);

    // Free-run mcycle for 10 cycles
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("run_cy_data_lo0", {32'd0, cy_ext_data_lo}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("run_cy_we_lo", {63'd0, cy_ext_we_lo}, 64'd1);
      chk("run_cy_we_hi", {63'd0, cy_ext_we_hi}, 64'd0);
      chk("run_ir_we", {62'd0, ir_ext_we_lo, ir_ext_we_hi}, 64'd0);
      @(negedge clk);
    end
    chk("run_cy_value", cy_value, 64'd10);
    chk("run_ir_value", ir_value, 64'd0);

    // Load mcycle lo, then mcycleh, then carry across the halves
    cy_wr_lo   = 1'b1;
    cy_wr_data = 32'hFFFF_FFFE;
    #1;
    chk("ld_lo_data", {cy_ext_data_hi, cy_ext_data_lo}, 64'h0000_0000_FFFF_FFFE);
    chk("ld_lo_we", {62'd0, cy_ext_we_lo, cy_ext_we_hi}, 64'd2);
    @(negedge clk);
    cy_wr_lo   = 1'b0;
    cy_wr_hi   = 1'b1;
    cy_wr_data = 32'h0;
    #1;
    chk("ld_hi_data", {cy_ext_data_hi, cy_ext_data_lo}, 64'h0000_0000_FFFF_FFFE);
    chk("ld_hi_we", {62'd0, cy_ext_we_lo, cy_ext_we_hi}, 64'd1);
    @(negedge clk);
    cy_wr_hi = 1'b0;
    #1;
    chk("cy_after_load", cy_value, 64'h0000_0000_FFFF_FFFE);
    chk("carry0_we_hi", {63'd0, cy_ext_we_hi}, 64'd0);
    chk("carry0_data_lo", {32'd0, cy_ext_data_lo}, 64'hFFFF_FFFF);
    @(negedge clk);
    chk("carry1_we_hi", {63'd0, cy_ext_we_hi}, 64'd1);
    chk("carry1_data", {cy_ext_data_hi, cy_ext_data_lo}, 64'h0000_0001_0000_0000);
    @(negedge clk);
    chk("carry_cy_value", cy_value, 64'h0000_0001_0000_0000);
    chk("carry_no_wrap", {63'd0, cy_wrap}, 64'd0);
    chk("carry2_we_hi", {63'd0, cy_ext_we_hi}, 64'd0);

    // minstret wrap from all-ones
    ir_wr_lo   = 1'b1;
    ir_wr_hi   = 1'b1;
    ir_wr_data = 32'hFFFF_FFFF;
    #1;
    chk("ir_ld_we", {62'd0, ir_ext_we_lo, ir_ext_we_hi}, 64'd3);
    chk("ir_ld_data", {ir_ext_data_hi, ir_ext_data_lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    ir_wr_lo = 1'b0;
    ir_wr_hi = 1'b0;
    retire   = 1'b1;
    #1;
    chk("ir_full", ir_value, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ir_load_no_wrap", {63'd0, ir_wrap}, 64'd0);
    chk("ir_wrap_we_hi", {63'd0, ir_ext_we_hi}, 64'd1);
    chk("ir_wrap_data", {ir_ext_data_hi, ir_ext_data_lo}, 64'd0);
    @(negedge clk);
    retire = 1'b0;
    chk("ir_wrapped_value", ir_value, 64'd0);
    chk("ir_wrap_pulse", {63'd0, ir_wrap}, 64'd1);
    @(negedge clk);
    chk("ir_wrap_cleared", {63'd0, ir_wrap}, 64'd0);
    chk("ir_value_held", ir_value, 64'd0);

    // Retire and software write in the same cycle: write wins
    retire     = 1'b1;
    ir_wr_lo   = 1'b1;
    ir_wr_data = 32'h0000_1234;
    #1;
    chk("rw_data_lo", {32'd0, ir_ext_data_lo}, 64'h1234);
    chk("rw_we", {62'd0, ir_ext_we_lo, ir_ext_we_hi}, 64'd2);
    @(negedge clk);
    ir_wr_lo = 1'b0;
    chk("rw_ir_value", ir_value, 64'h1234);
    chk("cy_before_inh", cy_value, 64'h0000_0001_0000_0004);

    // Inhibit mcycle for 5 cycles while instructions retire
    inhibit_cy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("inh_cy_we", {62'd0, cy_ext_we_lo, cy_ext_we_hi}, 64'd0);
      chk("inh_ir_we_lo", {63'd0, ir_ext_we_lo}, 64'd1);
      @(negedge clk);
    end
    inhibit_cy = 1'b0;
    retire     = 1'b0;
    chk("inh_cy_value", cy_value, 64'h0000_0001_0000_0004);
    chk("inh_ir_value", ir_value, 64'h1239);

    // Zero mcycle, count to 37, then assert reset asynchronously
    cy_wr_lo   = 1'b1;
    cy_wr_hi   = 1'b1;
    cy_wr_data = 32'h0;
    @(negedge clk);
    cy_wr_lo = 1'b0;
    cy_wr_hi = 1'b0;
    repeat (37) @(negedge clk);
    chk("cy_at_37", cy_value, 64'd37);
    #2;
    reset = 1'b1;
    #1;
    chk("async_cy_value", cy_value, 64'd0);
    chk("async_ir_value", ir_value, 64'd0);
    chk_we_all_zero("async_we");
    @(negedge clk);
    chk_we_all_zero("rst_hold_we");
    chk("rst_hold_cy", cy_value, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cy", cy_value, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_counters.md
Name: csr_counters

Overview:
- Owns the machine performance counters `mcycle`/`mcycleh` and `minstret`/`minstreth` as two 64-bit registers.
- Sits beside the generic CSR register instances. For each counter half it drives that instance's external write path (`ext_data`, `ext_write_enable`), so the instance always mirrors the live count.
- Software writes arrive as the write strobe plus the `direct_out` value of the targeted CSR instance. They are merged so that the software write wins over the increment.

Parameters:
- CounterWidth, 64, full counter width; must be even.
- HalfWidth, CounterWidth/2 (localparam), width of one CSR half; equals word width (32).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- retire  in  1  one instruction retires this cycle
- inhibit_cy  in  1  mcountinhibit.CY; 1 = mcycle frozen
- inhibit_ir  in  1  mcountinhibit.IR; 1 = minstret frozen
- cy_wr_lo  in  1  software write to mcycle this cycle
- cy_wr_hi  in  1  software write to mcycleh this cycle
- cy_wr_data  in  HalfWidth  new half value (direct_out of written CSR instance)
- ir_wr_lo  in  1  software write to minstret this cycle
- ir_wr_hi  in  1  software write to minstreth this cycle
- ir_wr_data  in  HalfWidth  new half value
- cy_ext_data_lo / cy_ext_data_hi  out  HalfWidth  next value to mcycle / mcycleh instances
- cy_ext_we_lo / cy_ext_we_hi  out  1  ext_write_enable to mcycle / mcycleh instances
- ir_ext_data_lo / ir_ext_data_hi  out  HalfWidth  next value to minstret / minstreth instances
- ir_ext_we_lo / ir_ext_we_hi  out  1  ext_write_enable to minstret / minstreth instances
- cy_value  out  CounterWidth  registered mcycle count
- ir_value  out  CounterWidth  registered minstret count
- cy_wrap  out  1  registered one-cycle pulse after mcycle wraps to 0
- ir_wrap  out  1  registered one-cycle pulse after minstret wraps to 0

Behaviour:
- Reset (async, active-high): counters = 0, cy_wrap = ir_wrap = 0. All ext_we outputs forced 0 while reset is high. ext_data outputs = 0.
- Each counter unit, with cnt = current register, computes next as follows, priority top-down:
  - wr_lo & wr_hi: next = {wr_data, wr_data}; no increment.
  - wr_lo: next = {cnt[hi], wr_data}; no increment.
  - wr_hi: next = {wr_data, cnt[lo]}; no increment.
  - Else, if tick & !inhibit: next = cnt + 1, modulo 2^CounterWidth.
  - Else: next = cnt.
- tick = 1 every cycle for mcycle; tick = retire for minstret.
- A retiring instruction that writes minstret(h) does not also increment it: the write wins.
- Write enables:
  - ext_we_lo = wr_lo | inc.
  - ext_we_hi = wr_hi | (inc & (cnt[lo] == all-ones)), i.e. only on carry into the upper half.
- ext_data_lo/hi = next[lo]/next[hi], combinational, valid the same cycle. The CSR instances and the internal register update on the same posedge, so there is zero-cycle skew between them.
- cy_value/ir_value equal the register contents and change on posedge only.
- Wrap: when an increment takes cnt from all-ones to 0, the wrap flag is 1 for exactly the following cycle. A software load of 0 is not a wrap.
- Inhibit takes effect the same cycle it is sampled; there is no pipeline delay.
- No handshake and no stall: every input is sampled every cycle.
- Reset asserted mid-count clears immediately, independent of clk.

Decomposition:
- types_pkg additions:
  - CounterT (logic [63:0]).
  - CSR address constants: MCYCLE 12'hB00, MINSTRET 12'hB02, MCYCLEH 12'hB80, MINSTRETH 12'hB82, MCOUNTINHIBIT 12'h320.
  - Inhibit bit indices: CY = 0, IR = 2.
- One sub-module, csr_counter_unit, instantiated twice (cycle, instret). Its ports are clk, reset, tick, inhibit, wr_lo, wr_hi, wr_data, ext_data_lo/hi, ext_we_lo/hi, value, wrap. The top level only wires tick sources.

Test Plan:
- Release reset, inhibit=0, retire=0 for 10 cycles -> cy_value = 10, ir_value = 0, cy_ext_we_lo = 1 every cycle, cy_ext_we_hi = 0.
- Load mcycle lo = 32'hFFFF_FFFE, mcycleh = 0, then run 2 cycles -> cy_ext_we_hi pulses once, exactly when lo goes FFFF_FFFF -> 0. cy_value = 64'h1_0000_0000; no cy_wrap.
- Load both halves of minstret = 32'hFFFF_FFFF, pulse retire once -> ir_value = 0; ir_wrap = 1 for one cycle, then 0.
- Assert retire and ir_wr_lo with data 32'h1234 in the same cycle -> ir_value = 32'h1234, not 32'h1235; ir_ext_data_lo = 32'h1234.
- inhibit_cy = 1 for 5 cycles with retire = 1 -> cy_value unchanged and cy_ext_we_* = 0; ir_value advances by 5.
- Assert reset asynchronously mid-cycle at count 37 -> cy_value = 0 before the next posedge; all ext_we = 0 while reset is high.
